regfile_scoreboard: RTL and testbench

- Parametrised successor to the 32x32 register file for the pipelined RISC-V core.
- Two combinational read ports and one synchronous write port.
- Per-register busy (scoreboard) bits that the issue stage uses for hazard detection.
- Hardware clear sequencer after reset, so software never reads X values and downstream stages need no separate reset of architectural state.

---
 rtl/regfile_scoreboard.sv | 124 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard -- parametrised register file with per-register busy
// (scoreboard) bits and a hardware clear sequencer that runs after reset.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : write-first forwarding on both read ports in RUN
//   undefined : reads return the pre-write value/busy bit in the write cycle
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   init_done          high once every register has been cleared
//   ra1/ra2            read addresses
//   rdata1/rdata2      combinational read data
//   busy1/busy2        combinational scoreboard bits for ra1/ra2
//   we, wa, wdata      synchronous write port (clears busy of wa)
//   rsv_en, rsv_addr   reserve request (sets busy of rsv_addr)
//   rsv_ack            combinational: reserve accepted this cycle
module regfile_scoreboard #(
  parameter  int unsigned XLEN     = 32,
  parameter  int unsigned NREGS    = 32,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            init_done,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wdata,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  output logic            rsv_ack
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          state;
  logic [AW-1:0]   clr_cnt;
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;

  logic run;
  logic wr_en;
  logic same_wr;
  logic rsv_set;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign run       = (state == S_RUN);
  assign init_done = run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_INIT;
      clr_cnt <= '0;
    end else if (state == S_INIT) begin
      clr_cnt <= clr_cnt + AW'(1);
      if (clr_cnt == LAST) state <= S_RUN;
    end
  end

  assign wr_en   = run & we & ~is_zero(wa);
  // A reserve of a busy register is still accepted when that register's
  // producer is retiring in the same cycle.
  assign same_wr = we & (wa == rsv_addr);
  assign rsv_ack = rsv_en & run & (~busy[rsv_addr] | same_wr);
  assign rsv_set = rsv_ack & ~is_zero(rsv_addr);

  // Storage has no reset; the INIT sequence clears it one entry per cycle.
  always_ff @(posedge clk) begin
    if (state == S_INIT) regs[clr_cnt] <= '0;
    else if (wr_en)      regs[wa]      <= wdata;
  end

  // Set is ordered after clear so a same-address write+reserve ends busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (wr_en)   busy[wa]       <= 1'b0;
      if (rsv_set) busy[rsv_addr] <= 1'b1;
    end
  end

  always_comb begin
    rdata1 = '0;
    busy1  = 1'b0;
    if (run && !is_zero(ra1)) begin
      rdata1 = regs[ra1];
      busy1  = busy[ra1];
`ifdef REGFILE_BYPASS_EN
      if (we && (wa == ra1)) begin
        rdata1 = wdata;
        busy1  = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    rdata2 = '0;
    busy2  = 1'b0;
    if (run && !is_zero(ra2)) begin
      rdata2 = regs[ra2];
      busy2  = busy[ra2];
`ifdef REGFILE_BYPASS_EN
      if (we && (wa == ra2)) begin
        rdata2 = wdata;
        busy2  = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard (default parameters, ZERO_REG=1).
// Honours REGFILE_BYPASS_EN when compiled with it.
module tb_regfile_scoreboard;

  localparam int NREGS = 32;
  localparam int XLEN  = 32;
  localparam int AW    = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            init_done;
  logic [AW-1:0]   ra1, ra2, wa, rsv_addr;
  logic [XLEN-1:0] rdata1, rdata2, wdata;
  logic            busy1, busy2, we, rsv_en, rsv_ack;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .ra1(ra1), .ra2(ra2), .rdata1(rdata1), .rdata2(rdata2),
    .busy1(busy1), .busy2(busy2),
    .we(we), .wa(wa), .wdata(wdata),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ack(rsv_ack)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: architectural view of the register file
  logic [XLEN-1:0] m_reg [NREGS];
  bit              m_busy [NREGS];
  bit              m_run;
  int              m_cnt;

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
    if (!m_run || a == 0) return '0;
    if (BYP && we && wa == a) return wdata;
    return m_reg[a];
  endfunction

  function automatic logic exp_bz(input logic [AW-1:0] a);
    if (!m_run || a == 0) return 1'b0;
    if (BYP && we && wa == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_ack();
    return rsv_en && m_run && (!m_busy[rsv_addr] || (we && wa == rsv_addr));
  endfunction

  task automatic set_in(input logic w, input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                        input logic r, input logic [AW-1:0] radr,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    we = w; wa = a; wdata = d; rsv_en = r; rsv_addr = radr; ra1 = a1; ra2 = a2;
  endtask

  // One rising edge; the model commits the inputs that were stable across it.
  task automatic tick();
    bit ack;
    @(posedge clk);
    if (rst_n) begin
      ack = exp_ack();
      if (!m_run) begin
        m_reg[m_cnt] = '0;
        m_cnt++;
        if (m_cnt == NREGS) m_run = 1'b1;
      end else begin
        if (we && wa != 0) begin
          m_reg[wa]  = wdata;
          m_busy[wa] = 1'b0;
        end
        if (ack && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
  endtask

  // Assert reset (async, mid-cycle), check reset outputs, release, and time
  // the clear sequence while hammering we/rsv_en; afterwards every register
  // must read zero and idle.
  task automatic test_reset();
    int cycles;
    #2;
    rst_n = 1'b0;
    set_in(1'b1, 5'd3, 32'hFFFF_0000, 1'b1, 5'd3, 5'd3, 5'd5);
    #1;
    model_reset();
    vectors++;
    if (init_done !== 1'b0 || rsv_ack !== 1'b0 || rdata1 !== '0 || busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: init_done=%b rsv_ack=%b rdata1=%h busy1=%b, required 0/0/0/0",
               init_done, rsv_ack, rdata1, busy1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycles = 0;
    while (!init_done && cycles < 100) begin
      set_in(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom),
             5'($urandom), 5'($urandom));
      #1;
      vectors++;
      if (rsv_ack !== 1'b0 || rdata1 !== '0 || rdata2 !== '0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
        miscompares++;
        $display("FAIL init_lockout: cycle %0d rsv_ack=%b rdata1=%h rdata2=%h busy=%b%b, required all 0",
                 cycles, rsv_ack, rdata1, rdata2, busy1, busy2);
      end
      tick();
      cycles++;
    end
    vectors++;
    if (cycles != NREGS) begin
      miscompares++;
      $display("FAIL init_latency: init_done after %0d cycles, required %0d", cycles, NREGS);
    end
    for (int i = 0; i < NREGS; i++) begin
      set_in(1'b0, '0, '0, 1'b0, '0, 5'(i), 5'(NREGS - 1 - i));
      #1;
      vectors++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
        miscompares++;
        $display("FAIL cleared_regs: addr %0d rdata1=%h rdata2=%h busy=%b%b, required 0",
                 i, rdata1, rdata2, busy1, busy2);
      end
      tick();
    end
  endtask

  task automatic test_write_read();
    set_in(1'b1, 5'd5, 32'h1234_5678, 1'b0, '0, 5'd1, 5'd2);
    tick();
    set_in(1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd5);
    #1;
    vectors++;
    if (rdata1 !== 32'h1234_5678 || rdata2 !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL write_read: rdata1=%h rdata2=%h, required 12345678", rdata1, rdata2);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    set_in(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0);
    #1;
    vectors++;
    if (rsv_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_rsv_ack: rsv_ack=%b, required 1", rsv_ack);
    end
    tick();
    set_in(1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd0);
    #1;
    vectors++;
    if (rdata1 !== 32'h0 || busy1 !== 1'b0 || rdata2 !== 32'h0 || busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_reg: rdata1=%h busy1=%b, required 0/0", rdata1, busy1);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    logic [XLEN-1:0] d;
    d = $urandom;
    set_in(1'b0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd7);
    #1;
    vectors++;
    if (rsv_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL rsv_first: rsv_ack=%b, required 1", rsv_ack);
    end
    tick();
    #1;
    vectors++;
    if (busy1 !== 1'b1 || rsv_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL rsv_second: busy1=%b rsv_ack=%b, required 1/0", busy1, rsv_ack);
    end
    tick();
    set_in(1'b1, 5'd7, d, 1'b0, '0, 5'd7, 5'd7);
    tick();
    set_in(1'b0, '0, '0, 1'b0, '0, 5'd7, 5'd7);
    #1;
    vectors++;
    if (busy1 !== 1'b0 || rdata1 !== d) begin
      miscompares++;
      $display("FAIL rsv_release: busy1=%b rdata1=%h, required 0/%h", busy1, rdata1, d);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    logic [XLEN-1:0] d;
    d = $urandom;
    set_in(1'b0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd9);
    tick();
    set_in(1'b1, 5'd9, d, 1'b1, 5'd9, 5'd9, 5'd9);
    #1;
    vectors++;
    if (rsv_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL same_addr_ack: rsv_ack=%b, required 1", rsv_ack);
    end
    tick();
    set_in(1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd9);
    #1;
    vectors++;
    if (busy1 !== 1'b1 || rdata1 !== d) begin
      miscompares++;
      $display("FAIL same_addr_state: busy1=%b rdata1=%h, required 1/%h", busy1, rdata1, d);
    end
    set_in(1'b0, '0, '0, 1'b1, 5'd3, 5'd3, 5'd3);
    tick();
    set_in(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd4, 5'd3, 5'd4);
    tick();
    #1;
    vectors++;
    if (busy1 !== 1'b0 || busy2 !== 1'b1 || rdata1 !== 32'h0000_0033) begin
      miscompares++;
      $display("FAIL diff_addr: busy3=%b busy4=%b rdata3=%h, required 0/1/00000033",
               busy1, busy2, rdata1);
    end
    set_in(1'b1, 5'd4, '0, 1'b0, '0, 5'd4, 5'd4);
    tick();
  endtask

  task automatic test_bypass();
    set_in(1'b1, 5'd12, 32'h1111_1111, 1'b1, 5'd20, 5'd0, 5'd0);
    tick();
    set_in(1'b0, '0, '0, 1'b1, 5'd12, 5'd0, 5'd0);
    tick();
    set_in(1'b1, 5'd12, 32'hA5A5_A5A5, 1'b0, '0, 5'd12, 5'd12);
    #1;
    vectors++;
    if (rdata1 !== (BYP ? 32'hA5A5_A5A5 : 32'h1111_1111) || busy1 !== !BYP || rdata2 !== rdata1) begin
      miscompares++;
      $display("FAIL bypass: rdata1=%h rdata2=%h busy1=%b, required %h/%h/%b", rdata1, rdata2, busy1,
               BYP ? 32'hA5A5_A5A5 : 32'h1111_1111, BYP ? 32'hA5A5_A5A5 : 32'h1111_1111, !BYP);
    end
    tick();
    set_in(1'b0, '0, '0, 1'b0, '0, 5'd12, 5'd20);
    #1;
    vectors++;
    if (rdata1 !== 32'hA5A5_A5A5 || busy1 !== 1'b0 || busy2 !== 1'b1) begin
      miscompares++;
      $display("FAIL post_bypass: rdata1=%h busy1=%b busy20=%b, required a5a5a5a5/0/1",
               rdata1, busy1, busy2);
    end
    tick();
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      #1;
      vectors++;
      if (rdata1 !== exp_rd(ra1) || rdata2 !== exp_rd(ra2) || busy1 !== exp_bz(ra1) ||
          busy2 !== exp_bz(ra2) || rsv_ack !== exp_ack()) begin
        miscompares++;
        $display("FAIL random[%0d]: rd1=%h rd2=%h b=%b%b ack=%b, required rd1=%h rd2=%h b=%b%b ack=%b",
                 k, rdata1, rdata2, busy1, busy2, rsv_ack,
                 exp_rd(ra1), exp_rd(ra2), exp_bz(ra1), exp_bz(ra2), exp_ack());
      end
      tick();
    end
  endtask

  // Dirty the file (DEADBEEF + reservations) so the next reset has work to do.
  task automatic dirty_regs();
    for (int i = 1; i < NREGS; i += 3) begin
      set_in(1'b1, 5'(i), 32'hDEAD_BEEF, 1'b1, 5'(i + 1), 5'(i), 5'(i));
      tick();
    end
    set_in(1'b0, '0, '0, 1'b0, '0, 5'd1, 5'd2);
    #1;
    vectors++;
    if (rdata1 !== 32'hDEAD_BEEF || busy2 !== 1'b1) begin
      miscompares++;
      $display("FAIL dirty_regs: rdata1=%h busy2=%b, required deadbeef/1", rdata1, busy2);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, '0, '0, 1'b0, '0, '0, '0);
    model_reset();
    test_reset();
    test_write_read();
    test_zero_reg();
    test_scoreboard();
    test_simultaneous();
    test_bypass();
    test_random(400);
    dirty_regs();
    test_reset();
    test_random(200);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
